// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM response, aligns and
// extends load data, hands {dest, result, gr_we} to WB and forwards to ID.
module mem_stage #(
    parameter int to_MEM_data_width = 70,
    parameter int to_WB_data_width  = 65
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [to_MEM_data_width-1:0] to_MEM_data,
    input  logic                         EX_to_MEM_valid,
    output logic                         MEM_allow_in,
    input  logic                         data_sram_data_ok,
    input  logic [31:0]                  data_sram_rdata,
    output logic [to_WB_data_width-1:0]  to_WB_data,
    output logic                         MEM_to_WB_valid,
    input  logic                         WB_allow_in,
    output logic [37:0]                  MEM_fwd,
    output logic                         MEM_fwd_stall
);

    logic                         mem_valid_q;
    logic [to_MEM_data_width-1:0] bus_q;
    logic                         rbuf_valid_q;
    logic [31:0]                  rbuf_q;

    logic        load_en, store_en, gr_we, mem_op, ready_go, fire, rbuf_set;
    logic [2:0]  load_type;
    logic [31:0] dest, alu_result, ld_word, ld_ext, final_result;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign load_en    = bus_q[69];
    assign load_type  = bus_q[68:66];
    assign store_en   = bus_q[65];
    assign dest       = bus_q[64:33];
    assign alu_result = bus_q[32:1];
    assign gr_we      = bus_q[0];

    assign mem_op          = load_en | store_en;
    assign ready_go        = ~mem_op | data_sram_data_ok | rbuf_valid_q;
    assign MEM_allow_in    = ~mem_valid_q | (ready_go & WB_allow_in);
    assign MEM_to_WB_valid = mem_valid_q & ready_go;
    assign fire            = MEM_to_WB_valid & WB_allow_in;
    // Only capture the response when WB is blocking; otherwise it bypasses straight through.
    assign rbuf_set        = mem_valid_q & mem_op & data_sram_data_ok & ~rbuf_valid_q & ~WB_allow_in;

    assign ld_word = rbuf_valid_q ? rbuf_q : data_sram_rdata;

    always_comb begin
        ld_byte = ld_word[7:0];
        case (alu_result[1:0])
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            2'd3:    ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
        ld_half = alu_result[1] ? ld_word[31:16] : ld_word[15:0];
        case (load_type)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = ld_word;
        endcase
    end

    assign final_result  = load_en ? ld_ext : alu_result;
    assign to_WB_data    = {dest, final_result, gr_we};
    assign MEM_fwd       = {mem_valid_q & gr_we & (~load_en | ready_go), dest[4:0], final_result};
    assign MEM_fwd_stall = mem_valid_q & load_en & ~ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q  <= 1'b0;
            bus_q        <= '0;
            rbuf_valid_q <= 1'b0;
            rbuf_q       <= '0;
        end else begin
            if (MEM_allow_in)
                mem_valid_q <= EX_to_MEM_valid;
            if (MEM_allow_in && EX_to_MEM_valid)
                bus_q <= to_MEM_data;
            if (fire)
                rbuf_valid_q <= 1'b0;
            else if (rbuf_set) begin
                rbuf_valid_q <= 1'b1;
                rbuf_q       <= data_sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: inputs change on the falling edge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [69:0] to_MEM_data;
    logic        EX_to_MEM_valid;
    logic        MEM_allow_in;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [64:0] to_WB_data;
    logic        MEM_to_WB_valid;
    logic        WB_allow_in;
    logic [37:0] MEM_fwd;
    logic        MEM_fwd_stall;

    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .clk(clk), .reset(reset), .to_MEM_data(to_MEM_data), .EX_to_MEM_valid(EX_to_MEM_valid),
        .MEM_allow_in(MEM_allow_in), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .to_WB_data(to_WB_data), .MEM_to_WB_valid(MEM_to_WB_valid),
        .WB_allow_in(WB_allow_in), .MEM_fwd(MEM_fwd), .MEM_fwd_stall(MEM_fwd_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [69:0] mk(input logic ld, input logic [2:0] lt, input logic st,
                                       input logic [31:0] dst, input logic [31:0] alu, input logic we);
        return {ld, lt, st, dst, alu, we};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1; EX_to_MEM_valid = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
        WB_allow_in = 1; to_MEM_data = '0;
        tick(); tick(); tick(); #1;
        total++; if (MEM_to_WB_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", MEM_to_WB_valid); end
        total++; if (MEM_allow_in !== 1'b1) begin bad++; $display("FAIL rst_allow got=%b exp=1", MEM_allow_in); end
        total++; if (to_WB_data !== 65'd0) begin bad++; $display("FAIL rst_wbdata got=%h exp=0", to_WB_data); end
        total++; if (MEM_fwd_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", MEM_fwd_stall); end
        total++; if (MEM_fwd !== 38'd0) begin bad++; $display("FAIL rst_fwd got=%h exp=0", MEM_fwd); end
        tick(); reset = 0;
    endtask

    task automatic test_alu();
        tick();
        to_MEM_data = mk(0, 3'b000, 0, 32'd5, 32'h1234_5678, 1); EX_to_MEM_valid = 1; WB_allow_in = 1;
        tick(); EX_to_MEM_valid = 0; #1;
        total++; if (MEM_to_WB_valid !== 1'b1) begin bad++; $display("FAIL alu_valid got=%b exp=1", MEM_to_WB_valid); end
        total++; if (to_WB_data !== {32'd5, 32'h1234_5678, 1'b1}) begin bad++; $display("FAIL alu_wbdata got=%h exp=%h", to_WB_data, {32'd5, 32'h1234_5678, 1'b1}); end
        total++; if (MEM_fwd !== {1'b1, 5'd5, 32'h1234_5678}) begin bad++; $display("FAIL alu_fwd got=%h exp=%h", MEM_fwd, {1'b1, 5'd5, 32'h1234_5678}); end
        tick(); #1;
        total++; if (MEM_to_WB_valid !== 1'b0) begin bad++; $display("FAIL alu_drain got=%b exp=0", MEM_to_WB_valid); end
    endtask

    task automatic test_lb_wait();
        to_MEM_data = mk(1, 3'b000, 0, 32'd3, 32'h0000_1003, 1); EX_to_MEM_valid = 1; WB_allow_in = 1;
        tick(); EX_to_MEM_valid = 0; #1;
        total++; if (MEM_fwd_stall !== 1'b1 || MEM_to_WB_valid !== 1'b0) begin bad++; $display("FAIL lb_stall1 stall=%b valid=%b exp 1/0", MEM_fwd_stall, MEM_to_WB_valid); end
        total++; if (MEM_fwd[37] !== 1'b0) begin bad++; $display("FAIL lb_fwdwe got=%b exp=0", MEM_fwd[37]); end
        tick(); #1;
        total++; if (MEM_fwd_stall !== 1'b1) begin bad++; $display("FAIL lb_stall2 got=%b exp=1", MEM_fwd_stall); end
        tick(); data_sram_data_ok = 1; data_sram_rdata = 32'h80FF_0102; #1;
        total++; if (MEM_fwd_stall !== 1'b0 || MEM_to_WB_valid !== 1'b1) begin bad++; $display("FAIL lb_done stall=%b valid=%b exp 0/1", MEM_fwd_stall, MEM_to_WB_valid); end
        total++; if (to_WB_data[32:1] !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_result got=%h exp=ffffff80", to_WB_data[32:1]); end
        total++; if (MEM_fwd !== {1'b1, 5'd3, 32'hFFFF_FF80}) begin bad++; $display("FAIL lb_fwd got=%h", MEM_fwd); end
        tick(); data_sram_data_ok = 0; #1;
        total++; if (MEM_to_WB_valid !== 1'b0) begin bad++; $display("FAIL lb_drain got=%b exp=0", MEM_to_WB_valid); end
    endtask

    // Load with the response arriving the first cycle in MEM.
    task automatic test_load_types();
        logic [2:0]  lt  [8] = '{3'b101, 3'b100, 3'b001, 3'b001, 3'b010, 3'b011, 3'b000, 3'b001};
        logic [31:0] ad  [8] = '{32'h1002, 32'h1003, 32'h1002, 32'h1001, 32'h1003, 32'h1000, 32'h1002, 32'h1000};
        logic [31:0] exp [8] = '{32'h0000_80FF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_0102,
                                 32'h80FF_0102, 32'h80FF_0102, 32'hFFFF_FFFF, 32'h0000_0102};
        for (int i = 0; i < 8; i++) begin
            to_MEM_data = mk(1, lt[i], 0, 32'd4, ad[i], 1); EX_to_MEM_valid = 1; WB_allow_in = 1;
            tick(); EX_to_MEM_valid = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h80FF_0102; #1;
            total++; if (MEM_to_WB_valid !== 1'b1 || to_WB_data[32:1] !== exp[i]) begin bad++; $display("FAIL load_type[%0d] valid=%b got=%h exp=%h", i, MEM_to_WB_valid, to_WB_data[32:1], exp[i]); end
            tick(); data_sram_data_ok = 0; data_sram_rdata = 32'h0;
        end
    endtask

    task automatic test_rbuf();
        to_MEM_data = mk(1, 3'b010, 0, 32'd6, 32'h0000_2000, 1); EX_to_MEM_valid = 1; WB_allow_in = 0;
        tick(); EX_to_MEM_valid = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD_BEEF; #1;
        total++; if (MEM_to_WB_valid !== 1'b1 || MEM_allow_in !== 1'b0) begin bad++; $display("FAIL rbuf_c0 valid=%b allow=%b exp 1/0", MEM_to_WB_valid, MEM_allow_in); end
        for (int i = 1; i < 3; i++) begin
            tick(); data_sram_data_ok = 0; data_sram_rdata = 32'h1111_1111; #1;
            total++; if (MEM_to_WB_valid !== 1'b1 || MEM_allow_in !== 1'b0 || to_WB_data[32:1] !== 32'hDEAD_BEEF)
                begin bad++; $display("FAIL rbuf_hold[%0d] valid=%b allow=%b data=%h exp 1/0/deadbeef", i, MEM_to_WB_valid, MEM_allow_in, to_WB_data[32:1]); end
        end
        tick(); WB_allow_in = 1; #1;
        total++; if (MEM_to_WB_valid !== 1'b1 || MEM_allow_in !== 1'b1 || to_WB_data[32:1] !== 32'hDEAD_BEEF)
            begin bad++; $display("FAIL rbuf_xfer valid=%b allow=%b data=%h exp 1/1/deadbeef", MEM_to_WB_valid, MEM_allow_in, to_WB_data[32:1]); end
        tick(); #1;
        total++; if (MEM_to_WB_valid !== 1'b0 || dut.rbuf_valid_q !== 1'b0) begin bad++; $display("FAIL rbuf_clear valid=%b rbuf_valid=%b exp 0/0", MEM_to_WB_valid, dut.rbuf_valid_q); end
    endtask

    task automatic test_back_to_back();
        to_MEM_data = mk(0, 3'b000, 1, 32'd7, 32'h0000_3000, 0); EX_to_MEM_valid = 1; WB_allow_in = 1;
        tick(); to_MEM_data = mk(0, 3'b000, 0, 32'd9, 32'h0000_ABCD, 1); #1;
        total++; if (MEM_to_WB_valid !== 1'b0 || MEM_allow_in !== 1'b0) begin bad++; $display("FAIL b2b_wait valid=%b allow=%b exp 0/0", MEM_to_WB_valid, MEM_allow_in); end
        tick(); data_sram_data_ok = 1; #1;
        total++; if (MEM_to_WB_valid !== 1'b1 || MEM_allow_in !== 1'b1 || to_WB_data !== {32'd7, 32'h0000_3000, 1'b0})
            begin bad++; $display("FAIL b2b_store valid=%b allow=%b data=%h", MEM_to_WB_valid, MEM_allow_in, to_WB_data); end
        tick(); data_sram_data_ok = 0; EX_to_MEM_valid = 0; #1;
        total++; if (MEM_to_WB_valid !== 1'b1 || to_WB_data !== {32'd9, 32'h0000_ABCD, 1'b1})
            begin bad++; $display("FAIL b2b_alu valid=%b data=%h", MEM_to_WB_valid, to_WB_data); end
        tick(); #1;
        total++; if (MEM_to_WB_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", MEM_to_WB_valid); end
    endtask

    task automatic test_reset_wait();
        to_MEM_data = mk(1, 3'b010, 0, 32'd8, 32'h0000_4000, 1); EX_to_MEM_valid = 1; WB_allow_in = 1;
        tick(); EX_to_MEM_valid = 0; #1;
        total++; if (MEM_fwd_stall !== 1'b1) begin bad++; $display("FAIL rw_stall got=%b exp=1", MEM_fwd_stall); end
        reset = 1;
        tick(); reset = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h5555_AAAA; #1;
        total++; if (MEM_to_WB_valid !== 1'b0 || MEM_allow_in !== 1'b1 || MEM_fwd_stall !== 1'b0)
            begin bad++; $display("FAIL rw_drop valid=%b allow=%b stall=%b exp 0/1/0", MEM_to_WB_valid, MEM_allow_in, MEM_fwd_stall); end
        tick(); data_sram_data_ok = 0; #1;
        total++; if (MEM_to_WB_valid !== 1'b0 || dut.rbuf_valid_q !== 1'b0) begin bad++; $display("FAIL rw_after valid=%b rbuf_valid=%b exp 0/0", MEM_to_WB_valid, dut.rbuf_valid_q); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_lb_wait();
        test_load_types();
        test_rbuf();
        test_back_to_back();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
